da_sop: RTL and testbench

DA_SOP -- requirements
Module: da_sop

---
 rtl/da_pkg.sv | 24 ++
 rtl/da_lut.sv | 35 +++
 rtl/da_sop.sv | 146 ++++++++++++++
 tb/tb_da_sop.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/da_pkg.sv
// Shared types and elaboration helpers for the distributed-arithmetic
// sum-of-products block.
package da_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Ceiling log2, with clog2(1) = 0.
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 32'sd0;
    v = 32'sd1;
    while (v < n) begin
      v = v * 32'sd2;
      r = r + 32'sd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/da_lut.sv
// Coefficient-sum table: entry a holds the sum of COEF[k] over every set bit k
// of a, sign-extended to the full LUT width.
module da_lut
  import da_pkg::*;
#(
  parameter int             N    = 3,
  parameter int             C    = 4,
  parameter logic [N*C-1:0] COEF = {4'd1, 4'd3, 4'd2},
  localparam int            LW   = C + clog2(N)
) (
  input  logic        [N-1:0]  addr_i,
  output logic signed [LW-1:0] lut_o
);

  localparam int DEPTH = 32'sd2 ** N;

  logic signed [LW-1:0] table_s [DEPTH];

  // Build every table entry from the packed coefficient vector.
  always_comb begin
    for (int a = 32'sd0; a < DEPTH; a++) begin
      table_s[a] = {LW{1'b0}};
      for (int k = 32'sd0; k < N; k++) begin
        table_s[a] = table_s[a] +
                     (a[k] ? LW'($signed(COEF[k*C +: C])) : {LW{1'b0}});
      end
    end
  end

  // Combinational read of the entry selected by the sample MSBs.
  always_comb begin
    lut_o = table_s[addr_i];
  end

endmodule

// File: rtl/da_sop.sv
// Bit-serial distributed-arithmetic sum of products: y = sum COEF[k]*x[k],
// processed MSB first, one bit per cycle, exact over W bits.
module da_sop
  import da_pkg::*;
#(
  parameter int             N       = 3,
  parameter int             B       = 3,
  parameter int             C       = 4,
  parameter int             XSIGNED = 0,
  parameter logic [N*C-1:0] COEF    = {4'd1, 4'd3, 4'd2},
  localparam int            L       = clog2(N),
  localparam int            W       = C + B + L
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N*B-1:0]       x_in,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic signed [W-1:0]  y,
  output logic                 out_valid,
  output logic signed [C+L-1:0] lut
);

  localparam int            CW   = clog2(B);
  localparam logic [CW-1:0] LAST = CW'(B - 32'sd1);

  state_e                state_q;
  state_e                state_d;
  logic [B-1:0]          x_q [N];
  logic [B-1:0]          x_d [N];
  logic signed [W-1:0]   acc_q;
  logic signed [W-1:0]   acc_d;
  logic signed [W-1:0]   y_q;
  logic signed [W-1:0]   y_d;
  logic [CW-1:0]         cnt_q;
  logic [CW-1:0]         cnt_d;
  logic                  out_valid_q;
  logic                  out_valid_d;
  logic [N-1:0]          addr_s;
  logic signed [C+L-1:0] lut_s;
  logic                  xfer_s;
  logic                  last_s;

  assign xfer_s = in_valid && in_ready;
  assign last_s = (cnt_q == LAST);

  // LUT address bit k is the current MSB of sample register k.
  always_comb begin
    addr_s = '0;
    for (int k = 32'sd0; k < N; k++) begin
      addr_s[k] = x_q[k][B-1];
    end
  end

  da_lut #(
    .N    (N),
    .C    (C),
    .COEF (COEF)
  ) u_lut (
    .addr_i (addr_s),
    .lut_o  (lut_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = xfer_s ? SHIFT : IDLE;
      SHIFT:   state_d = last_s ? DONE : SHIFT;
      DONE:    state_d = xfer_s ? SHIFT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake decode: a new vector is accepted whenever no shift is running.
  always_comb begin
    in_ready = 1'b0;
    case (state_q)
      IDLE:    in_ready = 1'b1;
      SHIFT:   in_ready = 1'b0;
      DONE:    in_ready = 1'b1;
      default: in_ready = 1'b0;
    endcase
  end

  // Datapath next state; the sign-bit slice is subtracted for signed inputs.
  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    x_d   = x_q;
    if (xfer_s) begin
      for (int k = 32'sd0; k < N; k++) begin
        x_d[k] = x_in[k*B +: B];
      end
      acc_d = '0;
      cnt_d = '0;
    end else if (state_q == SHIFT) begin
      for (int k = 32'sd0; k < N; k++) begin
        x_d[k] = {x_q[k][B-2:0], 1'b0};
      end
      if ((XSIGNED != 32'sd0) && (cnt_q == '0)) begin
        acc_d = (acc_q <<< 1'b1) - W'(lut_s);
      end else begin
        acc_d = (acc_q <<< 1'b1) + W'(lut_s);
      end
      cnt_d = cnt_q + CW'(1'b1);
    end else begin
      x_d = x_q;
    end
    out_valid_d = (state_q == SHIFT) && last_s;
    y_d         = out_valid_d ? acc_d : y_q;
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      y_q         <= '0;
      out_valid_q <= 1'b0;
      for (int k = 32'sd0; k < N; k++) begin
        x_q[k] <= '0;
      end
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      y_q         <= y_d;
      out_valid_q <= out_valid_d;
      x_q         <= x_d;
    end
  end

  assign y         = y_q;
  assign out_valid = out_valid_q;
  assign lut       = lut_s;

endmodule

// File: tb/tb_da_sop.sv
// Directed and random checks of da_sop in four parameter configurations
// against an integer sum-of-products reference.
module tb_da_sop;

  logic clk;
  logic reset;

  // u0: unsigned, B=3, COEF 2,3,1
  logic [8:0]         x0;
  logic               v0, r0, ov0;
  logic signed [8:0]  y0;
  logic signed [5:0]  l0;
  // u1: signed, B=4, COEF 2,3,1
  logic [11:0]        x1;
  logic               v1, r1, ov1;
  logic signed [9:0]  y1;
  logic signed [5:0]  l1;
  // u2: signed, B=4, COEF all -8
  logic [11:0]        x2;
  logic               v2, r2, ov2;
  logic signed [9:0]  y2;
  logic signed [5:0]  l2;
  // u3: unsigned, B=3, COEF all 7
  logic [8:0]         x3;
  logic               v3, r3, ov3;
  logic signed [8:0]  y3;
  logic signed [5:0]  l3;

  int n_asserts = 0;
  int n_fail    = 0;
  int coef_a [3] = '{2, 3, 1};

  da_sop #(.N(3), .B(3), .C(4), .XSIGNED(0), .COEF(12'h132)) u0 (
    .clk(clk), .reset(reset), .x_in(x0), .in_valid(v0), .in_ready(r0),
    .y(y0), .out_valid(ov0), .lut(l0));
  da_sop #(.N(3), .B(4), .C(4), .XSIGNED(1), .COEF(12'h132)) u1 (
    .clk(clk), .reset(reset), .x_in(x1), .in_valid(v1), .in_ready(r1),
    .y(y1), .out_valid(ov1), .lut(l1));
  da_sop #(.N(3), .B(4), .C(4), .XSIGNED(1), .COEF(12'h888)) u2 (
    .clk(clk), .reset(reset), .x_in(x2), .in_valid(v2), .in_ready(r2),
    .y(y2), .out_valid(ov2), .lut(l2));
  da_sop #(.N(3), .B(3), .C(4), .XSIGNED(0), .COEF(12'h777)) u3 (
    .clk(clk), .reset(reset), .x_in(x3), .in_valid(v3), .in_ready(r3),
    .y(y3), .out_valid(ov3), .lut(l3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: plain integer sum of coefficient * sample value.
  function automatic int sop(input logic [11:0] xv, input int b, input bit sgn,
                             input int cf [3]);
    int s;
    int xk;
    s = 0;
    for (int k = 0; k < 3; k++) begin
      xk = int'((xv >> (k * b)) & ((12'd1 << b) - 12'd1));
      if (sgn && xk >= (1 << (b - 1))) xk -= (1 << b);
      s += cf[k] * xk;
    end
    return s;
  endfunction

  // Reference: coefficients selected by the sample MSBs.
  function automatic int msb_sum(input logic [11:0] xv, input int b, input int cf [3]);
    int s;
    s = 0;
    for (int k = 0; k < 3; k++) begin
      if (xv[k * b + b - 1]) s += cf[k];
    end
    return s;
  endfunction

  task automatic run0(input logic [8:0] xv, output int lat, output int yv);
    @(posedge clk); #1;
    x0 = xv;
    v0 = 1'b1;
    @(negedge clk);
    check("run0_ready", int'(r0), 1);
    lat = 0;
    do begin
      @(posedge clk); #1;
      if (lat == 0) v0 = 1'b0;
      lat++;
      @(negedge clk);
    end while (!ov0 && lat < 20);
    yv = int'(y0);
  endtask

  task automatic run1(input logic [11:0] xv, output int lat, output int yv);
    @(posedge clk); #1;
    x1 = xv;
    v1 = 1'b1;
    @(negedge clk);
    check("run1_ready", int'(r1), 1);
    lat = 0;
    do begin
      @(posedge clk); #1;
      if (lat == 0) v1 = 1'b0;
      lat++;
      @(negedge clk);
    end while (!ov1 && lat < 20);
    yv = int'(y1);
  endtask

  initial begin
    int lat;
    int yv;
    int n;
    int pulses;
    logic [8:0]  xa;
    logic [8:0]  xb;
    logic [11:0] xr;

    reset = 1'b1;
    x0 = '0; v0 = 1'b0;
    x1 = '0; v1 = 1'b0;
    x2 = '0; v2 = 1'b0;
    x3 = '0; v3 = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_y0", int'(y0), 0);
    check("rst_ov0", int'(ov0), 0);
    check("rst_lut0", int'(l0), 0);
    check("rst_y1", int'(y1), 0);
    check("rst_ov1", int'(ov1), 0);
    check("rst_lut1", int'(l1), 0);
    check("rst_y2", int'(y2), 0);
    check("rst_lut2", int'(l2), 0);
    check("rst_y3", int'(y3), 0);
    check("rst_lut3", int'(l3), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("rdy_after_rst0", int'(r0), 1);
    check("rdy_after_rst2", int'(r2), 1);
    check("rdy_after_rst3", int'(r3), 1);

    // Unsigned example: x=1,3,7 -> 18, four cycles after transfer
    run0({3'd7, 3'd3, 3'd1}, lat, yv);
    check("y_unsigned", yv, 18);
    check("lat_unsigned", lat, 4);
    @(negedge clk);
    check("pulse_single", int'(ov0), 0);
    check("y_held", int'(y0), 18);

    // Signed example: x=-1,-8,7 -> -19
    run1({4'd7, 4'd8, 4'd15}, lat, yv);
    check("y_signed", yv, -19);
    check("lat_signed", lat, 5);

    // Extreme magnitudes
    @(posedge clk); #1;
    x2 = {3{4'h8}}; v2 = 1'b1;
    x3 = {3{3'd7}}; v3 = 1'b1;
    @(posedge clk); #1;
    v2 = 1'b0; v3 = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("y_neg_extreme", int'(y2), 192);
    check("y_pos_extreme", int'(y3), 147);
    check("ov_extreme", int'(ov2 | ov3), 0);

    // in_valid pulsed mid-shift with other data is ignored
    @(posedge clk); #1;
    xa = {3'd6, 3'd2, 3'd5};
    x0 = xa; v0 = 1'b1;
    @(posedge clk); #1;
    v0 = 1'b0;
    @(negedge clk);
    check("rdy_in_shift", int'(r0), 0);
    check("lut_first_bit", int'(l0), msb_sum(12'(xa), 3, coef_a));
    @(posedge clk); #1;
    x0 = 9'h1FF; v0 = 1'b1;
    @(posedge clk); #1;
    v0 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("ignore_ov", int'(ov0), 1);
    check("ignore_y", int'(y0), sop(12'(xa), 3, 1'b0, coef_a));

    // Back-to-back with in_valid held high
    xa = 9'($urandom);
    xb = 9'($urandom);
    @(posedge clk); #1;
    x0 = xa; v0 = 1'b1;
    @(posedge clk); #1;
    x0 = xb;
    n = 1;
    @(negedge clk);
    while (!ov0 && n < 20) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    check("b2b_lat1", n, 4);
    check("b2b_y1", int'(y0), sop(12'(xa), 3, 1'b0, coef_a));
    check("b2b_rdy_done", int'(r0), 1);
    @(posedge clk); #1;
    v0 = 1'b0;
    n = 1;
    @(negedge clk);
    while (!ov0 && n < 20) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    check("b2b_lat2", n, 4);
    check("b2b_y2", int'(y0), sop(12'(xb), 3, 1'b0, coef_a));

    // Reset two cycles into a shift aborts the result
    @(posedge clk); #1;
    x0 = {3'd4, 3'd4, 3'd4}; v0 = 1'b1;
    @(posedge clk); #1;
    v0 = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    pulses = 0;
    repeat (8) begin
      @(negedge clk);
      if (ov0) pulses++;
    end
    check("abort_pulses", pulses, 0);
    check("abort_y", int'(y0), 0);
    check("abort_rdy", int'(r0), 1);
    run0({3'd2, 3'd5, 3'd3}, lat, yv);
    check("after_abort_y", yv, sop(12'({3'd2, 3'd5, 3'd3}), 3, 1'b0, coef_a));

    // Boundary samples
    run0(9'd0, lat, yv);
    check("zero_y", yv, 0);
    run1(12'hFFF, lat, yv);
    check("minus_one_y", yv, -6);

    // Random vectors on both coefficient sets
    for (int i = 0; i < 16; i++) begin
      xr = 12'($urandom);
      run0(xr[8:0], lat, yv);
      check("rnd_u_y", yv, sop({3'd0, xr[8:0]}, 3, 1'b0, coef_a));
      check("rnd_u_lat", lat, 4);
      xr = 12'($urandom);
      run1(xr, lat, yv);
      check("rnd_s_y", yv, sop(xr, 4, 1'b1, coef_a));
      check("rnd_s_lat", lat, 5);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
